// File: rtl/cla_adder_pipe.sv
// ---------------------------------------------------------------------------
// cla_adder_pipe -- pipelined carry-lookahead adder/subtractor (multdiv path)
//
// The WIDTH-bit add is cut into NBLK = WIDTH/BLOCK lookahead slices. Stage k
// resolves slice k with a flat lookahead network and registers the slice sum
// and its carry-out. The operands and the partial sum travel with the token.
// The last stage's register is the output register, so latency is NBLK.
//
// Optional feature (macro CLA_SAT_EN): adds input 'sat'. When it is set and
// the result overflows, sum is clamped to the signed max/min value.
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   in_valid / in_ready   operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, sub, cin        operands; sub=1 gives a-b, and then cin is ignored
//   sat                   (CLA_SAT_EN only) clamp the sum on overflow
//   out_valid / out_ready result handshake
//   sum, cout, ovf        result, carry out of the MSB, signed overflow
// ---------------------------------------------------------------------------

// One lookahead slice. Each carry is built directly from the g/p terms of
// the slice and the slice carry-in (no ripple chain). The last iteration
// forms the block generate/propagate, which gives the block carry-out.
module cla_slice #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             cm   // carry into the top bit of the slice
);
  logic [BLOCK-1:0] p, g;
  logic [BLOCK:0]   c;
  logic             gt, pt;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c    = '0;
    gt   = 1'b0;
    pt   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      // gt = G[i:0] and pt = P[i:0], both expanded as flat sums of products
      gt = g[i];
      pt = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gt = gt | (pt & g[j]);
        pt = pt & p[j];
      end
      c[i+1] = gt | (pt & ci);
    end
  end

  assign s  = p ^ c[BLOCK-1:0];
  assign co = c[BLOCK];
  assign cm = c[BLOCK-1];
endmodule

module cla_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef CLA_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK");
  end
  if (BLOCK != 2 && BLOCK != 4 && BLOCK != 8 && BLOCK != 16) begin : g_bad_block
    $error("cla_adder_pipe: BLOCK must be 2, 4, 8 or 16");
  end

  // Token carried down the pipe: operands (b already conditioned),
  // the partial sum, the carry into the next slice and the saturate request.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             sat;
  } tok_t;

  logic [NBLK:1] vld_pipe;   // vld_pipe[k] = valid bit of stage k-1's register
  logic          advance;
  logic          sat_in;
  logic          ovf_q;

`ifdef CLA_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  // Every stage moves together, and bubbles move like tokens. This keeps
  // the latency fixed at NBLK cycles whenever the consumer is not stalling.
  assign advance   = ~vld_pipe[NBLK] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[NBLK];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= NBLK; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    tok_t             t_in, t_nxt, t_q;
    logic             v_in;
    logic [BLOCK-1:0] s_sl;
    logic             co, cm;

    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1.
      assign t_in = {a, (sub ? ~b : b), {WIDTH{1'b0}}, (sub | cin), sat_in};
      assign v_in = in_valid;
    end else begin : g_next
      assign t_in = g_stg[k-1].t_q;
      assign v_in = vld_pipe[k];
    end

    cla_slice #(.BLOCK(BLOCK)) u_slice (
      .a  (t_in.a[k*BLOCK +: BLOCK]),
      .b  (t_in.b[k*BLOCK +: BLOCK]),
      .ci (t_in.c),
      .s  (s_sl),
      .co (co),
      .cm (cm)
    );

    always_comb begin
      t_nxt = t_in;
      t_nxt.s[k*BLOCK +: BLOCK] = s_sl;
      t_nxt.c = co;
      // Overflow means both operands have the same effective sign, so the
      // sign of a picks the clamp direction.
      if (k == NBLK - 1 && t_in.sat && (co ^ cm))
        t_nxt.s = t_in.a[WIDTH-1] ? SMIN : SMAX;
    end

    // Data loads only with a valid token, so the output register keeps the
    // last delivered result while bubbles pass through.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)               t_q <= '0;
      else if (advance && v_in)   t_q <= t_nxt;
    end

    if (k == NBLK - 1) begin : g_last
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)               ovf_q <= 1'b0;
        else if (advance && v_in)   ovf_q <= co ^ cm;  // carry into MSB ^ carry out
      end
    end
  end

  assign sum  = g_stg[NBLK-1].t_q.s;
  assign cout = g_stg[NBLK-1].t_q.c;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
module tb_cla_adder_pipe;
  localparam int WIDTH = 32;
  localparam int BLOCK = 8;
  localparam int NBLK  = WIDTH / BLOCK;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             sub = 1'b0, cin = 1'b0, sat = 1'b0;
  logic             out_valid, out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf;

  cla_adder_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
`ifdef CLA_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, popped = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer addition on WIDTH+1 bits; overflow from the signs.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s, input logic ci, input logic st);
    exp_t e;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] be;
    be  = s ? ~y : y;
    r   = {1'b0, x} + {1'b0, be} + {{WIDTH{1'b0}}, (s ? 1'b1 : ci)};
    e.s = r[WIDTH-1:0];
    e.c = r[WIDTH];
    e.v = (x[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    if (st && e.v) e.s = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return e;
  endfunction

  // Called at a negedge: checks the outputs against the scoreboard, tracks
  // both handshakes for the coming edge, then advances one clock.
  task automatic tick();
    exp_t e;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
    if (q.size() == 0) chk("no_phantom", {31'b0, out_valid}, '0);
    else if (out_valid) begin
      e = q[0];
      chk("sum", sum, e.s);
      chk("cout", {31'b0, cout}, {31'b0, e.c});
      chk("ovf", {31'b0, ovf}, {31'b0, e.v});
    end
    if (out_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      popped++;
    end
    if (in_valid && in_ready && reset_n) q.push_back(model(a, b, sub, cin, sat));
    @(posedge clock);
    @(negedge clock);
  endtask

  // One isolated op with out_ready=1: checks latency and the given constants.
  task automatic run1(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic s, input logic ci, input logic st,
                      input logic [WIDTH-1:0] es, input logic ec, input logic ev);
    int lat;
    a = x; b = y; sub = s; cin = ci; sat = st; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, NBLK);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, ev});
    tick();
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [WIDTH-1:0] ta [6] = '{32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678, 32'h0, 32'h8000_0000};
  logic [WIDTH-1:0] tb [6] = '{32'h2, 32'h1, 32'h1, 32'h1111_1111, 32'h1, 32'h1};
  logic             tsub[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    logic hold;
    logic saw_stall;
    int   base, n, iss;

    // Reset state
    @(negedge clock); @(negedge clock);
    chk("rst_out_valid", {31'b0, out_valid}, '0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", {31'b0, cout}, '0);
    chk("rst_ovf", {31'b0, ovf}, '0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);

    // Directed plan vectors
    run1("inc_ff", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run1("ripple", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run1("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`ifdef CLA_SAT_EN
    run1("sat_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run1("sat_neg", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`endif
    run1("sub_neg", 32'h5, 32'h7, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run1("sub_pos", 32'h7, 32'h5, 1'b1, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0);

    // Back-to-back 6 ops, consumer stalls on cycles 6-8
    base = popped; iss = 0; saw_stall = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      in_valid = (iss < 6);
      if (iss < 6) begin a = ta[iss]; b = tb[iss]; sub = tsub[iss]; cin = 1'b0; sat = 1'b0; end
      out_ready = !(c >= 6 && c <= 8);
      #1;
      if (!in_ready && out_valid && !out_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) iss++;
      tick();
    end
    in_valid = 1'b0;
    chk("stall_in_ready_drop", {31'b0, saw_stall}, 32'd1);
    chk("stall_count", popped - base, 6);

    // Reset mid-flight discards three in-flight ops
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, '0);
    q.delete();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    run1("post_rst", 32'h0000_1000, 32'h0000_0234, 1'b0, 1'b1, 1'b0, 32'h0000_1235, 1'b0, 1'b0);

    // Randomized traffic with random back-pressure
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = rnd_op(); b = rnd_op();
        sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
`ifdef CLA_SAT_EN
        sat = $urandom_range(0, 1);
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hold = in_valid && !in_ready;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the multdiv datapath. Successor to the fixed 8-bit CLA block.
- The WIDTH-bit operation is split into NBLK = WIDTH/BLOCK lookahead slices. One slice is resolved per pipeline stage; the carry is registered between stages.
- Valid/ready handshake on both input and output, with full back-pressure, so the multiplier/divider sequencers can issue one add per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, bits per lookahead slice (= bits resolved per stage); legal values 2, 4, 8, 16.
- NBLK, WIDTH/BLOCK (derived, localparam), number of pipeline stages and fixed latency in cycles.

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands presented.
- in_ready, output, 1, pipeline can accept operands this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- sub, input, 1, 1 = compute A-B, 0 = compute A+B.
- cin, input, 1, carry-in for add; ignored when sub=1.
- out_valid, output, 1, result held on outputs.
- out_ready, input, 1, consumer accepts result.
- sum, output, WIDTH, result bits.
- cout, output, 1, carry out of the MSB (for sub: 1 = no borrow).
- ovf, output, 1, signed two's-complement overflow.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All stage valid bits cleared, so out_valid=0.
  - sum=0, cout=0, ovf=0; in_ready=1 once reset is released.
  - Reset asserted mid-operation discards every in-flight operation; no partial result ever appears.
- Operand conditioning at issue:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage k (0..NBLK-1):
  - Computes slice k: per-bit p=a^b, g=a&b, block P/G, and BLOCK-wide lookahead sum using the registered carry from stage k-1 (c0 for k=0).
  - Registers the slice sum and block carry-out.
  - Unprocessed upper operand slices travel with the token; completed lower sum slices are carried forward unchanged.
- Stall rule:
  - advance = ~out_valid | out_ready. All stages shift together when advance=1 and hold otherwise.
  - in_ready = advance (combinational from out_valid/out_ready).
  - Empty bubbles (valid=0) propagate like tokens; there is no bubble collapsing.
- Acceptance and latency:
  - Input is taken when in_valid & in_ready.
  - The result appears exactly NBLK cycles later if advance stays 1.
  - Throughput: 1 result per cycle.
- Outputs:
  - sum, cout and ovf are registered and stable while out_valid & ~out_ready.
  - Output data is held from the last transfer when out_valid=0; it is not cleared.
- Overflow: ovf = carry into MSB XOR carry out of MSB.
- Wrap-around: modular WIDTH-bit result, e.g. 0xFFFFFFFF + 1 gives sum=0, cout=1, ovf=0.
- Simultaneous events:
  - An accept at stage 0 and a result handoff in the same cycle are legal.
  - in_valid=1 while in_ready=0: operands are not captured; the source must hold them.
- NBLK=1 degenerates to a single registered CLA with latency 1.

Optional Feature:
- Macro: CLA_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), sampled with the operands and piped alongside.
  - When sat=1 and ovf=1, sum is clamped at the output register: to 0x7FF..F if the operands' effective sign was positive, 0x800..0 if negative.
  - ovf is still reported as 1.
  - Latency is unchanged.
- Undefined: no sat port; sum is always the modular result.

Test Plan (WIDTH=32, BLOCK=8):
- a=0x0000_00FF, b=0x0000_0001, sub=0, cin=0, out_ready=1 -> after 4 cycles sum=0x0000_0100, cout=0, ovf=0.
- a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0, cout=1, ovf=0 (carry ripples through all 4 stages).
- a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, ovf=1; with CLA_SAT_EN and sat=1 -> sum=0x7FFF_FFFF, ovf=1.
- a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0; a=7, b=5, sub=1 -> sum=2, cout=1.
- Back-to-back issue of 6 ops with out_ready=0 on cycles 6-8:
  - in_ready drops while out_valid=1 and out_ready=0.
  - Results emerge in order with no loss or duplication; the output is held stable during the stall.
- Issue 3 ops, assert reset_n=0 for 1 cycle mid-flight -> out_valid stays 0 and none of the 3 results ever appears; the next op after reset completes normally in 4 cycles.
